apb_req_bridge: RTL and testbench

- Protocol bridge that sits directly upstream of the peripheral APB interconnect and drives its slave port.
- Converts the SoC core-side request/grant/rvalid data interface into APB3 master transfers.
- Two checks run before any APB access:
  - Peripheral window range check: out-of-window requests get an error response and never reach the bus.
  - Partial-write rejection.
- Per-access watchdog: an APB slave that never asserts pready cannot hang the core.

---
 rtl/apb_req_bridge.sv | 117 +++++++++++
 tb/tb_apb_req_bridge.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_bridge.sv
// Bridge from the core request/grant/rvalid interface to a single APB3 master port.
// It rejects out-of-window and partial-write requests locally and bounds each ACCESS phase with a watchdog.
module apb_req_bridge #(
  parameter int unsigned            ADDR_WIDTH     = 32,
  parameter int unsigned            DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0]  WIN_START      = 32'h1A10_0000,
  parameter logic [ADDR_WIDTH-1:0]  WIN_END        = 32'h1A11_FFFF,
  parameter int unsigned            TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    gnt_o,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic                    pwrite_o,
  output logic                    psel_o,
  output logic                    penable_o,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pready_i,
  input  logic                    pslverr_i
);

  // Core side: a request is taken in any cycle where req_i && gnt_o; gnt_o is
  // only offered in IDLE. Each taken request yields exactly one rvalid_o pulse,
  // which cannot be stalled. APB side: standard SETUP -> ACCESS, ending on pready_i.

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t          state;
  logic [WD_W-1:0] wd_cnt;
  logic            in_window;
  logic            legal;
  logic            timeout;

  assign gnt_o     = (state == IDLE) && req_i;
  assign in_window = (addr_i >= WIN_START) && (addr_i <= WIN_END);
  assign legal     = in_window && (!we_i || (&be_i));
  // wd_cnt holds the number of earlier wait cycles, so it equals
  // TIMEOUT_CYCLES-1 during the TIMEOUT_CYCLES-th ACCESS cycle.
  assign timeout   = (TIMEOUT_CYCLES != 0) && !pready_i &&
                     (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      wd_cnt    <= '0;
      rvalid_o  <= 1'b0;
      err_o     <= 1'b0;
      rdata_o   <= '0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
      pwrite_o  <= 1'b0;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
    end else begin
      rvalid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_o) begin
            if (legal) begin
              // APB address/data only change when a transfer actually starts.
              state    <= SETUP;
              psel_o   <= 1'b1;
              paddr_o  <= addr_i;
              pwrite_o <= we_i;
              pwdata_o <= wdata_i;
              wd_cnt   <= '0;
            end else begin
              rvalid_o <= 1'b1;
              err_o    <= 1'b1;
              rdata_o  <= '0;
            end
          end
        end
        SETUP: begin
          state     <= ACCESS;
          penable_o <= 1'b1;
        end
        ACCESS: begin
          if (pready_i) begin
            state     <= IDLE;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            rvalid_o  <= 1'b1;
            err_o     <= pslverr_i;
            rdata_o   <= pwrite_o ? '0 : prdata_i;
          end else if (timeout) begin
            state     <= IDLE;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            rvalid_o  <= 1'b1;
            err_o     <= 1'b1;
            rdata_o   <= '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          psel_o    <= 1'b0;
          penable_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_bridge.sv
// Self-checking bench for apb_req_bridge: directed plan items plus randomized
// transactions checked against a transaction-level model of the bridge.
module tb_apb_req_bridge;

  localparam int          AW  = 32;
  localparam int          DW  = 32;
  localparam int          TO  = 4;
  localparam logic [31:0] WS  = 32'h1A10_0000;
  localparam logic [31:0] WEN = 32'h1A11_FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          we = 1'b0;
  logic [3:0]    be = 4'h0;
  logic [DW-1:0] wdata = '0;
  logic          gnt, rvalid, err, pwrite, psel, penable;
  logic [DW-1:0] rdata, pwdata;
  logic [AW-1:0] paddr;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  logic [DW:0] exp_q[$];

  apb_req_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WIN_START(WS), .WIN_END(WEN), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .paddr_o(paddr), .pwdata_o(pwdata), .pwrite_o(pwrite), .psel_o(psel),
    .penable_o(penable), .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  always #5 clk = ~clk;

  // One core transaction with an APB slave that inserts wait_n wait states.
  task automatic run_txn(input logic [31:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] wd, input int wait_n, input logic serr,
                         input logic [31:0] prd, input string tag);
    logic legal, timed, apb_ok, got;
    int exp_acc, exp_lat, exp_psel, cyc, acc, psel_n, first_psel, first_pen, lat;
    logic [DW:0] exp_r, obs_r;
    legal    = (a >= WS) && (a <= WEN) && (!w || b == 4'hF);
    timed    = legal && (wait_n >= TO);
    exp_acc  = !legal ? 0 : (timed ? TO : wait_n + 1);
    exp_lat  = !legal ? 1 : exp_acc + 2;
    exp_psel = legal ? exp_acc + 1 : 0;
    exp_q.push_back({((!legal || timed) ? 1'b1 : serr),
                     ((!legal || timed || w) ? 32'h0 : prd)});

    @(negedge clk);
    req = 1'b1; addr = a; we = w; be = b; wdata = wd; prdata = prd; pslverr = serr;
    #1;
    vectors++;
    if (gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL %s gnt: got %b want 1", tag, gnt);
    end

    cyc = 0; acc = 0; psel_n = 0; first_psel = -1; first_pen = -1;
    apb_ok = 1'b1; got = 1'b0; lat = -1; obs_r = '0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      req = 1'b0;
      pready = 1'b0;
      if (psel) begin
        psel_n++;
        if (first_psel < 0) first_psel = cyc;
        if (paddr !== a || pwrite !== w || (w && pwdata !== wd)) apb_ok = 1'b0;
      end
      if (penable) begin
        acc++;
        if (first_pen < 0) first_pen = cyc;
        if (!psel) apb_ok = 1'b0;
        pready = (acc == wait_n + 1);
      end
      if (rvalid) begin
        got = 1'b1;
        lat = cyc;
        obs_r = {err, rdata};
      end
    end
    pready = 1'b0;

    vectors++;
    if (lat != exp_lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat);
    end
    vectors++;
    if (psel_n != exp_psel) begin
      miscompares++;
      $display("FAIL %s psel_cycles: got %0d want %0d", tag, psel_n, exp_psel);
    end
    vectors++;
    if (acc != exp_acc) begin
      miscompares++;
      $display("FAIL %s access_cycles: got %0d want %0d", tag, acc, exp_acc);
    end
    if (legal) begin
      vectors++;
      if (first_psel != 1 || first_pen != 2) begin
        miscompares++;
        $display("FAIL %s apb_phase: psel@%0d penable@%0d want 1/2", tag, first_psel, first_pen);
      end
    end
    vectors++;
    if (!apb_ok) begin
      miscompares++;
      $display("FAIL %s apb_signals: paddr %h pwrite %b pwdata %h want %h %b %h",
               tag, paddr, pwrite, pwdata, a, w, wd);
    end
    exp_r = exp_q.pop_front();
    if (got) begin
      vectors++;
      if (obs_r !== exp_r) begin
        miscompares++;
        $display("FAIL %s response: got err=%b rdata=%h want err=%b rdata=%h",
                 tag, obs_r[DW], obs_r[DW-1:0], exp_r[DW], exp_r[DW-1:0]);
      end
      @(negedge clk);
      vectors++;
      if (rvalid !== 1'b0 || {err, rdata} !== obs_r) begin
        miscompares++;
        $display("FAIL %s hold: rvalid=%b err=%b rdata=%h want 0/%b/%h",
                 tag, rvalid, err, rdata, obs_r[DW], obs_r[DW-1:0]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({rvalid, err, psel, penable, pwrite} !== 5'b0 || paddr !== '0 ||
        pwdata !== '0 || rdata !== '0) begin
      miscompares++;
      $display("FAIL reset_state: rv=%b err=%b psel=%b pen=%b pw=%b paddr=%h pwdata=%h rdata=%h want all 0",
               rvalid, err, psel, penable, pwrite, paddr, pwdata, rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_txn(32'h1A10_2000, 1'b0, 4'h0, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, "read_zero_wait");
    run_txn(32'h1A11_FFFF, 1'b1, 4'hF, 32'h0000_00A5, 3, 1'b0, 32'h7777_7777, "write_win_end");
    run_txn(32'h1A12_0000, 1'b0, 4'hF, 32'h0, 0, 1'b0, 32'h1111_1111, "read_win_end_plus1");
    run_txn(32'h1A10_0000, 1'b1, 4'h3, 32'hCAFE_0001, 0, 1'b0, 32'h0, "partial_write");
    run_txn(32'h1A0F_FFFF, 1'b0, 4'hF, 32'h0, 0, 1'b0, 32'h2222_2222, "read_win_start_minus1");
    run_txn(32'h1A10_0000, 1'b0, 4'h0, 32'h0, 1, 1'b0, 32'h3333_3333, "read_win_start");
    run_txn(32'h1A10_0010, 1'b0, 4'hF, 32'h0, 0, 1'b1, 32'h0000_1234, "read_pslverr");
  endtask

  task automatic test_timeout();
    run_txn(32'h1A10_4000, 1'b0, 4'hF, 32'h0, 100, 1'b0, 32'hABCD_0000, "timeout_read");
    run_txn(32'h1A10_4004, 1'b0, 4'hF, 32'h0, 3, 1'b0, 32'hABCD_0001, "pready_last_cycle");
    run_txn(32'h1A10_4008, 1'b1, 4'hF, 32'h5A5A_5A5A, 100, 1'b0, 32'h0, "timeout_write");
  endtask

  task automatic test_back_to_back();
    logic [7:0] gnt_hist, rv_hist;
    logic [DW:0] exp_r;
    gnt_hist = '0; rv_hist = '0;
    exp_q.push_back({1'b0, 32'h5555_0001});
    exp_q.push_back({1'b0, 32'h5555_0002});
    @(negedge clk);
    req = 1'b1; addr = WS + 32'h100; we = 1'b0; be = 4'hF; prdata = 32'h5555_0001; pslverr = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 4) begin
        req = 1'b0;
        prdata = 32'h5555_0002;
      end
      pready = penable;
      #1;
      gnt_hist[c] = gnt;
      rv_hist[c]  = rvalid;
      if (rvalid) begin
        exp_r = exp_q.pop_front();
        vectors++;
        if ({err, rdata} !== exp_r) begin
          miscompares++;
          $display("FAIL b2b_response@%0d: got err=%b rdata=%h want err=%b rdata=%h",
                   c, err, rdata, exp_r[DW], exp_r[DW-1:0]);
        end
      end
    end
    pready = 1'b0;
    vectors++;
    if (gnt_hist !== 8'b0000_1001) begin
      miscompares++;
      $display("FAIL b2b_gnt_cycles: got %b want 00001001", gnt_hist);
    end
    vectors++;
    if (rv_hist !== 8'b0100_1000) begin
      miscompares++;
      $display("FAIL b2b_rvalid_cycles: got %b want 01001000", rv_hist);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_access();
    int rv_n;
    @(negedge clk);
    req = 1'b1; addr = WS + 32'h200; we = 1'b0; be = 4'hF; pready = 1'b0;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    vectors++;
    if (psel !== 1'b1 || penable !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_in_access: psel=%b penable=%b want 1/1", psel, penable);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (psel !== 1'b0 || penable !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_async_drop: psel=%b penable=%b want 0/0", psel, penable);
    end
    @(negedge clk);
    rst = 1'b0;
    rv_n = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rvalid) rv_n++;
    end
    vectors++;
    if (rv_n != 0) begin
      miscompares++;
      $display("FAIL mid_reset_no_rvalid: got %0d pulses want 0", rv_n);
    end
    run_txn(WS + 32'h300, 1'b0, 4'hF, 32'h0, 1, 1'b0, 32'h0BAD_F00D, "after_reset");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [3:0]  b;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: a = WS;
        1: a = WEN;
        2: a = WS - 32'h1;
        3: a = WEN + 32'h1;
        4: a = WS + 32'($urandom_range(0, 32'h1FFFF));
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      run_txn(a, 1'($urandom), b, $urandom, int'($urandom_range(0, 6)),
              1'($urandom_range(0, 3) == 0), $urandom, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
